pdm_mic_ctrl: RTL and testbench
===============================

Name: pdm_mic_ctrl

Overview:
- Capture sequencer for the Nexys4 PDM microphone.
- Generates the mic clock from the system clock and samples the 1-bit PDM stream on the edge selected by channel select.
- Counts ones over a fixed window of PDM bits to form a PCM sample, and hands each sample downstream over a valid/ready handshake.
- Sits between the mic pins and the audio sample buffer/FIFO. Replaces free-running capture with start/stop control and overrun reporting.

Parameters:
- CLK_DIV, 25, system-clock cycles per mic-clock half period (100 MHz -> 2 MHz mclk); legal >= 1
- WINDOW, 64, PDM bits accumulated per PCM sample; legal >= 2
- SW, $clog2(WINDOW+1), sample width (derived, localparam)

Ports:
- clk  in  1  system clock; all logic on posedge clk
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = run capture, 0 = stop after the current mclk period
- lr_sel  in  1  channel select driven to mic; 0 = sample on mclk rising edge, 1 = on falling edge
- dataint  in  1  PDM data from mic
- mclk  out  1  mic clock, 50% duty
- lr  out  1  registered copy of lr_sel to mic
- sample  out  SW  PCM sample = ones count in window, 0..WINDOW
- sample_valid  out  1  sample holds unconsumed data
- sample_ready  in  1  downstream accepts when sample_valid && sample_ready
- overrun  out  1  sticky; a window completed while sample_valid was high and not accepted
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: mclk=0, lr=0, sample=0, sample_valid=0, overrun=0, busy=0; div counter=0, bit counter=0, accumulator=0, state=IDLE. Reset mid-capture aborts immediately with no partial sample.
- lr <= lr_sel every cycle. lr_sel is sampled only when the state is IDLE; it is frozen for the whole RUN.
- Divider: counts 0..CLK_DIV-1 while RUN or STOP. At terminal count it wraps to 0 and toggles mclk. The cycle in which mclk toggles is the edge event.
- Capture event: edge event where the new mclk matches the frozen select (rising when sel=0, falling when sel=1). On it, dataint is sampled in that same cycle, acc += dataint, and bitcnt increments.
- Window close: the capture event with bitcnt==WINDOW-1 is the closing event. Its bit counts toward the window, and the next window starts empty.
  - If sample_valid is 0, or the same cycle has an accept: sample <= acc + dataint and sample_valid <= 1 on the next edge. Latency is one clk after the last bit.
  - Otherwise: the new sample is dropped, the old sample is kept, and overrun <= 1.
- Handshake: an accept clears sample_valid unless a window closes in the same cycle; in that case the new sample loads and sample_valid stays 1. sample is stable while valid && !ready. sample_ready has no combinational path to any output.
- overrun is cleared only by reset.
- FSM:
  - IDLE: mclk=0, counters=0. enable=1 -> RUN.
  - RUN: free-running mclk and capture. enable=0 -> STOP.
  - STOP: capture is disabled and the partial window is discarded (acc, bitcnt cleared on entry). Continues dividing until the edge event that drives mclk to 0, then -> IDLE. If mclk is already 0 on entry, it waits for the next falling edge, so the mic never sees a runt pulse.
  - enable re-asserted during STOP has no effect until IDLE is reached.
- A pending sample (sample_valid) survives STOP/IDLE until accepted.
- Arithmetic: acc is SW bits and cannot overflow (max WINDOW). Bitcnt is $clog2(WINDOW) bits and wraps to 0 at close.

Decomposition:
- Shared package mic_pkg: state typedef {IDLE, RUN, STOP}, default CLK_DIV and WINDOW constants.
- One sub-module is natural: mic_clk_gen (divider + mclk toggle + rise/fall event strobes, with run input and a "parked low" status output). The FSM, accumulator and handshake stay in pdm_mic_ctrl.

Test Plan:
- CLK_DIV=2, WINDOW=8, lr_sel=0, dataint=1, ready=1 -> mclk period of 4 clk; first sample=8 with sample_valid high 1 clk, one sample per 32 clk.
- dataint alternating per capture event (1,0,1,0...) -> every sample=4. lr_sel=1 -> bits taken on falling edges, still 4.
- ready=0 for 3 windows -> sample holds the first value, overrun rises at the close of window 2 and stays 1. ready=1 -> one accept, valid drops.
- Accept coincident with window close -> new sample loads, sample_valid stays 1, no overrun.
- enable drops after 5 bits -> no sample produced, mclk finishes low, busy falls when mclk reaches 0. Re-enable -> next window starts at bitcnt 0.
- reset asserted mid-window with sample_valid=1 -> next cycle all outputs 0, and the next capture restarts cleanly.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared definitions for the PDM microphone capture path: FSM state encoding
// and the default mic-clock divider and sample window.
package mic_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t STOP = 2'd2;

  localparam int DEF_CLK_DIV = 25;
  localparam int DEF_WINDOW  = 64;

endpackage

// File: rtl/mic_clk_gen.sv
// Mic clock generator: divides clk down to a 50% duty mclk and flags the
// cycle in which mclk is about to rise or fall.
module mic_clk_gen
  import mic_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic mclk,
  output logic rise,
  output logic fall,
  output logic parked
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          tc;

  assign tc = run && (div == DIV_LAST);

  // NOTE: registered state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      div  <= '0;
      mclk <= 1'b0;
    end else if (!run) begin
      div <= '0;
    end else if (tc) begin
      div  <= '0;
      mclk <= ~mclk;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Strobes describe the mclk value that appears after this clk edge.
  assign rise   = tc & ~mclk;
  assign fall   = tc &  mclk;
  assign parked = ~mclk;

endmodule

// File: rtl/pdm_mic_ctrl.sv
// PDM microphone capture sequencer: start/stop FSM, ones-count accumulation
// over a fixed window, and a valid/ready sample output with sticky overrun.
module pdm_mic_ctrl
  import mic_pkg::*;
#(
  parameter  int CLK_DIV = DEF_CLK_DIV,
  parameter  int WINDOW  = DEF_WINDOW,
  localparam int SW      = $clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          lr_sel,
  input  logic          dataint,
  output logic          mclk,
  output logic          lr,
  output logic [SW-1:0] sample,
  output logic          sample_valid,
  input  logic          sample_ready,
  output logic          overrun,
  output logic          busy
);

  localparam int BW = $clog2(WINDOW);
  localparam logic [BW-1:0] BIT_LAST = BW'(WINDOW - 1);

  state_t        state;
  state_t        state_nxt;
  logic          sel;
  logic [SW-1:0] acc;
  logic [BW-1:0] bitcnt;
  logic          run;
  logic          rise;
  logic          fall;
  logic          parked;
  logic          cap;
  logic          close_win;
  logic          stop_entry;

  assign run = (state != IDLE);

  mic_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .mclk   (mclk),
    .rise   (rise),
    .fall   (fall),
    .parked (parked)
  );

  assign cap        = (state == RUN) && (sel ? fall : rise);
  assign close_win  = cap && (bitcnt == BIT_LAST);
  assign stop_entry = (state == RUN) && !enable;

  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && parked) state_nxt = RUN;
      RUN:     if (!enable)          state_nxt = STOP;
      STOP:    if (fall)             state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Channel select is frozen while capturing; lr itself just follows lr_sel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel   <= 1'b0;
      lr    <= 1'b0;
    end else begin
      state <= state_nxt;
      lr    <= lr_sel;
      if (state == IDLE) sel <= lr_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stop_entry) begin
      acc    <= '0;
      bitcnt <= '0;
    end else if (close_win) begin
      acc    <= '0;
      bitcnt <= '0;
    end else if (cap) begin
      acc    <= acc + SW'(dataint);
      bitcnt <= bitcnt + 1'b1;
    end
  end

  // A closing window either publishes (slot free or being accepted) or is
  // dropped and flagged; a plain accept only frees the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (close_win) begin
      if (!sample_valid || sample_ready) begin
        sample       <= acc + SW'(dataint);
        sample_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// Directed bench for pdm_mic_ctrl with CLK_DIV=2, WINDOW=8 (mclk period 4 clk,
// one window per 32 clk); expected values are worked out by hand below.
module tb_pdm_mic_ctrl;

  localparam int CLK_DIV = 2;
  localparam int WINDOW  = 8;
  localparam int SW      = $clog2(WINDOW + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          lr_sel;
  logic          dataint;
  logic          mclk;
  logic          lr;
  logic [SW-1:0] sample;
  logic          sample_valid;
  logic          sample_ready;
  logic          overrun;
  logic          busy;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  int          mode   = 0;   // 0 hold dataint, 1 toggle after rises, 2 toggle after falls
  logic        prev_mclk = 1'b0;

  pdm_mic_ctrl #(
    .CLK_DIV (CLK_DIV),
    .WINDOW  (WINDOW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .lr_sel       (lr_sel),
    .dataint      (dataint),
    .mclk         (mclk),
    .lr           (lr),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Alternating data source: flips dataint just after each capturing mclk edge.
  always @(posedge clk) begin
    #2;
    if (mode == 1 && mclk && !prev_mclk) dataint = ~dataint;
    else if (mode == 2 && !mclk && prev_mclk) dataint = ~dataint;
    prev_mclk = mclk;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < budget);
    check(tag, int'(sample_valid), 1);
  endtask

  task automatic wait_idle(input string tag, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    check(tag, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          rises;
    logic        pm;
    int unsigned t0;
    logic        exp_mclk [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; enable = 1'b0; lr_sel = 1'b0; dataint = 1'b1; sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_mclk", int'(mclk), 0);
    check("rst_lr", int'(lr), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_busy", int'(busy), 0);

    // All ones, rising-edge capture: 8 rises at clk 3,7,..,31 -> valid after clk 31.
    enable = 1'b1;
    wait_valid("first_valid", 40, n);
    check("first_latency", n, 31);
    check("first_sample", int'(sample), 8);
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) check("valid_one_clk", int'(sample_valid), 0);
      check($sformatf("mclk_wave_%0d", i), int'(mclk), int'(exp_mclk[i]));
    end
    wait_valid("second_valid", 40, n);
    check("sample_period", int'(cyc - t0), 32);
    check("second_sample", int'(sample), 8);

    // Alternating bits on rising edges -> 4 per window.
    mode = 1; dataint = 1'b1;
    wait_valid("alt_rise_valid_a", 40, n);
    check("alt_rise_sample_a", int'(sample), 4);
    wait_valid("alt_rise_valid_b", 40, n);
    check("alt_rise_sample_b", int'(sample), 4);

    // Restart with falling-edge capture.
    enable = 1'b0;
    wait_idle("stop_a", 20, n);
    lr_sel = 1'b1; mode = 2; dataint = 1'b1; enable = 1'b1;
    @(negedge clk);
    check("lr_follows_sel", int'(lr), 1);
    check("busy_in_run", int'(busy), 1);
    wait_valid("alt_fall_valid_a", 60, n);
    check("alt_fall_sample_a", int'(sample), 4);
    wait_valid("alt_fall_valid_b", 40, n);
    check("alt_fall_sample_b", int'(sample), 4);

    // Accept lands exactly on the next close: the all-zero window replaces 4.
    sample_ready = 1'b0; mode = 0; dataint = 1'b0;
    repeat (31) @(negedge clk);
    check("held_before_close", int'(sample), 4);
    sample_ready = 1'b1;
    @(negedge clk);
    check("coinc_valid", int'(sample_valid), 1);
    check("coinc_sample", int'(sample), 0);
    check("coinc_overrun", int'(overrun), 0);
    @(negedge clk);
    check("coinc_then_accept", int'(sample_valid), 0);

    // Overrun: hold an 8, let zero windows close with ready low.
    dataint = 1'b1;
    wait_valid("ovr_first_valid", 40, n);
    check("ovr_first_sample", int'(sample), 8);
    sample_ready = 1'b0; dataint = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!overrun && n < 40);
    check("overrun_at_win2", n, 32);
    check("ovr_hold_sample", int'(sample), 8);
    repeat (34) @(negedge clk);
    check("overrun_sticky", int'(overrun), 1);
    check("ovr_sample_win3", int'(sample), 8);
    check("ovr_valid_win3", int'(sample_valid), 1);
    sample_ready = 1'b1;
    @(negedge clk);
    check("ovr_accept_valid", int'(sample_valid), 0);
    check("ovr_after_accept", int'(overrun), 1);

    // Stop after 5 bits: no sample, mclk parks low as busy falls.
    enable = 1'b0;
    wait_idle("stop_b", 20, n);
    check("idle_mclk_low", int'(mclk), 0);
    lr_sel = 1'b0; dataint = 1'b1; enable = 1'b1;
    n = 0; rises = 0; pm = mclk;
    while (rises < 5 && n < 60) begin
      @(negedge clk);
      n++;
      if (mclk && !pm) rises++;
      pm = mclk;
    end
    check("five_rises", rises, 5);
    enable = 1'b0;
    wait_idle("stop_c", 20, n);
    check("stop_latency", n, 2);
    check("stop_mclk_low", int'(mclk), 0);
    check("no_partial_sample", int'(sample_valid), 0);
    enable = 1'b1;
    wait_valid("restart_valid", 40, n);
    check("restart_latency", n, 31);
    check("restart_sample", int'(sample), 8);

    // Reset mid-window with a pending sample.
    sample_ready = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_valid", int'(sample_valid), 1);
    lr_sel = 1'b1; reset = 1'b1;
    @(negedge clk);
    check("mid_rst_mclk", int'(mclk), 0);
    check("mid_rst_lr", int'(lr), 0);
    check("mid_rst_sample", int'(sample), 0);
    check("mid_rst_valid", int'(sample_valid), 0);
    check("mid_rst_overrun", int'(overrun), 0);
    check("mid_rst_busy", int'(busy), 0);
    reset = 1'b0; lr_sel = 1'b0; sample_ready = 1'b1;
    wait_valid("post_rst_valid", 40, n);
    check("post_rst_latency", n, 31);
    check("post_rst_sample", int'(sample), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
